// File: rtl/sine_rom_arbiter_if.sv
// Bundle of requester, ROM and response signals shared by sine_rom_arbiter and its environment.
// slave = arbiter side, master = requesters + ROM + consumer side.
`timescale 1ns/1ps
interface sine_rom_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int PHASE_WIDTH  = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*PHASE_WIDTH-1:0] req_phase;
    logic [NUM_REQ-1:0]             req_ready;
    logic [PHASE_WIDTH-1:0]         rom_phase;
    logic [SAMPLE_WIDTH-1:0]        rom_sample;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [ID_WIDTH-1:0]            rsp_id;
    logic [SAMPLE_WIDTH-1:0]        rsp_sample;

    modport slave (
        input  req_valid, req_phase, rom_sample, rsp_ready,
        output req_ready, rom_phase, rsp_valid, rsp_id, rsp_sample
    );

    modport master (
        output req_valid, req_phase, rom_sample, rsp_ready,
        input  req_ready, rom_phase, rsp_valid, rsp_id, rsp_sample
    );
endinterface

// File: rtl/sine_rom_arbiter.sv
// Shares one registered sine ROM among NUM_REQ phase requesters; samples return tagged through a
// credit-protected FIFO. Define SINE_ROM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
`timescale 1ns/1ps
module sine_rom_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PHASE_WIDTH  = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int OUT_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sine_rom_arbiter_if.slave bus
);
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W    = $clog2(OUT_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Requesters hold phase stable while valid and unaccepted; ready never waits on a transfer.

    logic [PHASE_WIDTH-1:0]  rom_phase_q, rom_phase_d;
    logic [ID_WIDTH-1:0]     s1_id_q, s1_id_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [ID_WIDTH-1:0]     s2_id_q, s2_id_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
`ifndef SINE_ROM_ARB_FIXED_PRIO_EN
    logic [ID_WIDTH-1:0]     last_q, last_d;
`endif

    logic [ID_WIDTH-1:0]     mem_id     [OUT_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_sample [OUT_DEPTH];

    logic                    grant_any;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic [PHASE_WIDTH-1:0]  grant_phase;
    logic [CNT_W:0]          used_credit;
    logic                    credit_ok;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    head_valid;

    always_comb begin : arb_comb
`ifdef SINE_ROM_ARB_FIXED_PRIO_EN
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = ID_WIDTH'(k);
            end
        end
`else
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        // Search begins just after the last winner so every requester gets a turn.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_WIDTH'(idx);
            end
        end
`endif
    end

    assign grant_phase = bus.req_phase[int'(grant_idx)*PHASE_WIDTH +: PHASE_WIDTH];

    // Everything already issued holds a FIFO slot; a pop this cycle frees it only next cycle.
    assign used_credit = {1'b0, count_q}
                       + {{CNT_W{1'b0}}, s1_valid_q}
                       + {{CNT_W{1'b0}}, s2_valid_q};
    assign credit_ok   = used_credit < (CNT_W + 1)'(OUT_DEPTH);
    assign accept      = rst_n && grant_any && credit_ok;

    assign bus.req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    assign head_valid = (count_q != '0);
    assign push       = s2_valid_q;
    assign pop        = head_valid && bus.rsp_ready;

    always_comb begin : next_state_comb
        rom_phase_d = rom_phase_q;
        s1_id_d     = s1_id_q;
        if (accept) begin
            rom_phase_d = grant_phase;
            s1_id_d     = grant_idx;
        end
        s1_valid_d = accept;
        s2_valid_d = s1_valid_q;
        s2_id_d    = s1_id_q;
`ifndef SINE_ROM_ARB_FIXED_PRIO_EN
        last_d = accept ? grant_idx : last_q;
`endif
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_phase_q <= '0;
            s1_id_q     <= '0;
            s1_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            s2_valid_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifndef SINE_ROM_ARB_FIXED_PRIO_EN
            last_q      <= ID_WIDTH'(NUM_REQ - 1);
`endif
        end else begin
            rom_phase_q <= rom_phase_d;
            s1_id_q     <= s1_id_d;
            s1_valid_q  <= s1_valid_d;
            s2_id_q     <= s2_id_d;
            s2_valid_q  <= s2_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`ifndef SINE_ROM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr_q]     <= s2_id_q;
            mem_sample[wr_ptr_q] <= bus.rom_sample;
        end
    end

    assign bus.rom_phase  = rom_phase_q;
    assign bus.rsp_valid  = head_valid;
    assign bus.rsp_id     = head_valid ? mem_id[rd_ptr_q]     : '0;
    assign bus.rsp_sample = head_valid ? mem_sample[rd_ptr_q] : '0;
endmodule

// File: tb/tb_sine_rom_arbiter.sv
// Directed bench for sine_rom_arbiter with a registered ROM model rom[a] = a*3, a = phase[31:24].
`timescale 1ns/1ps
module tb_sine_rom_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [31:0] ph [4];
    logic [17:0] exp_q [$];
    logic [17:0] e;

    sine_rom_arbiter_if #(.NUM_REQ(4), .PHASE_WIDTH(32), .SAMPLE_WIDTH(16)) bus ();

    sine_rom_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_sample <= 16'(bus.rom_phase[31:24]) * 16'd3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    function automatic logic [15:0] rom_val(input logic [31:0] p);
        return 16'(p[31:24]) * 16'd3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_phases();
        for (int i = 0; i < 4; i++) bus.req_phase[i*32 +: 32] = ph[i];
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_head(input string tag);
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_id"}, 32'(bus.rsp_id), 32'(e[17:16]));
            check({tag, "_sample"}, 32'(bus.rsp_sample), 32'(e[15:0]));
        end
    endtask

    task automatic push_exp(input int id);
        exp_q.push_back({2'(id), rom_val(ph[id])});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4; i++) ph[i] = 32'h1000_0000 * 32'(i + 1);
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.rsp_ready  = 1'b0;
        bus.req_phase  = '0;

        // Reset: outputs quiet regardless of inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.rsp_ready = 1'($urandom_range(0, 1));
            bus.req_phase = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_rom_phase", bus.rom_phase, 32'd0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
            check("rst_rsp_sample", 32'(bus.rsp_sample), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_phases();
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        #1;
        check("first_grant", 32'(bus.req_ready), 32'h1);
        push_exp(0);

`ifndef SINE_ROM_ARB_FIXED_PRIO_EN
        // Round-robin at full throughput
        for (int k = 1; k < 12; k++) begin
            step();
            check("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            push_exp(k % 4);
            check("rr_rom_phase", bus.rom_phase, ph[(k - 1) % 4]);
            if (k >= 3) check_head("rr_rsp");
            else check("rr_rsp_empty", 32'(bus.rsp_valid), 32'd0);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) step();
            check_head("rr_drain");
        end
        step();
        check("rr_idle_valid", 32'(bus.rsp_valid), 32'd0);
        check("rr_idle_phase", bus.rom_phase, ph[3]);

        // Full backpressure: exactly four accepts, then drain in order
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            check("bp_grant", 32'(bus.req_ready), (k < 4) ? 32'(1 << k) : 32'd0);
            if (k < 4) push_exp(k);
            check("bp_valid", 32'(bus.rsp_valid), (k >= 3) ? 32'd1 : 32'd0);
            if (k >= 3) begin
                check("bp_hold_id", 32'(bus.rsp_id), 32'd0);
                check("bp_hold_sample", 32'(bus.rsp_sample), 32'(rom_val(ph[0])));
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) step();
            check_head("bp_rsp");
            check("bp_resume", 32'(bus.req_ready), (j == 0) ? 32'd0 : 32'(1 << ((j - 1) % 4)));
            if (j >= 1) push_exp((j - 1) % 4);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) step();
            check_head("bp_drain");
        end
        step();
        check("bp_idle", 32'(bus.rsp_valid), 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
`else
        @(negedge clk);
        bus.req_valid = '0;
        repeat (6) @(negedge clk);
        exp_q.delete();
`endif

        // Single lookup from requester 2
        @(negedge clk);
        ph[2] = 32'h4000_0000;
        drive_phases();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0100;
        #1;
        check("single_grant", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("single_rom_phase", bus.rom_phase, 32'h4000_0000);
        check("single_t1_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        check("single_t2_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        check("single_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_id", 32'(bus.rsp_id), 32'd2);
        check("single_sample", 32'(bus.rsp_sample), 32'h00C0);
        step();
        check("single_after", 32'(bus.rsp_valid), 32'd0);
        ph[2] = 32'h3000_0000;
        drive_phases();

`ifndef SINE_ROM_ARB_FIXED_PRIO_EN
        // Reset with two lookups in flight and two in the FIFO
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            check("rm_grant", 32'(bus.req_ready), 32'(1 << ((k + 3) % 4)));
        end
        step();
        check("rm_full", 32'(bus.req_ready), 32'd0);
        check("rm_pre_valid", 32'(bus.rsp_valid), 32'd1);
        rst_n = 1'b0;
        bus.req_valid = '0;
        #1;
        check("rm_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rm_rst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rm_no_stale", 32'(bus.rsp_valid), 32'd0);
        end
        @(negedge clk);
        ph[1] = 32'h7F00_0000;
        drive_phases();
        bus.req_valid = 4'b0010;
        #1;
        check("rm_post_grant", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("rm_post_t1", 32'(bus.rsp_valid), 32'd0);
        step();
        check("rm_post_t2", 32'(bus.rsp_valid), 32'd0);
        step();
        check("rm_post_valid", 32'(bus.rsp_valid), 32'd1);
        check("rm_post_id", 32'(bus.rsp_id), 32'd1);
        check("rm_post_sample", 32'(bus.rsp_sample), 32'h017D);
`else
        // Fixed priority: requester 0 always beats requester 3
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1001;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step();
            check("fp_grant0", 32'(bus.req_ready), 32'h1);
        end
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #1;
        check("fp_grant3", 32'(bus.req_ready), 32'h8);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (6) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
